// File: rtl/l2_req_responder_pkg.sv
// Spandex message/width definitions used by the L2 request responder, plus its local FSM state type.
// Optional macro SPX_REQ_RSP_DELAY_EN adds the DELAY state.
`ifndef LINE_ADDR_BITS
`define LINE_ADDR_BITS 28
`endif
`ifndef BITS_PER_WORD
`define BITS_PER_WORD 32
`endif
`ifndef WORDS_PER_LINE
`define WORDS_PER_LINE 4
`endif
`ifndef BITS_PER_LINE
`define BITS_PER_LINE (`BITS_PER_WORD * `WORDS_PER_LINE)
`endif
`ifndef INVACK_CNT_WIDTH
`define INVACK_CNT_WIDTH 3
`endif

package l2_req_responder_pkg;

  typedef logic [4:0] mix_msg_t;

  localparam mix_msg_t REQ_S      = 5'd0;
  localparam mix_msg_t REQ_Odata  = 5'd1;
  localparam mix_msg_t REQ_WT     = 5'd2;
  localparam mix_msg_t REQ_O      = 5'd3;
  localparam mix_msg_t REQ_WB     = 5'd4;
  localparam mix_msg_t REQ_V      = 5'd5;

  localparam mix_msg_t RSP_S      = 5'd0;
  localparam mix_msg_t RSP_Odata  = 5'd1;
  localparam mix_msg_t RSP_WT     = 5'd2;
  localparam mix_msg_t RSP_O      = 5'd3;
  localparam mix_msg_t RSP_WB_ACK = 5'd4;
  localparam mix_msg_t RSP_V      = 5'd5;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    READ,
    WRITE,
`ifdef SPX_REQ_RSP_DELAY_EN
    DELAY,
`endif
    RESP
  } l2_req_responder_state_t;

  function automatic logic req_supported(input mix_msg_t m);
    return (m == REQ_V) || (m == REQ_Odata) || (m == REQ_O) ||
           (m == REQ_WT) || (m == REQ_WB);
  endfunction

  function automatic logic req_is_write(input mix_msg_t m);
    return (m == REQ_WT) || (m == REQ_WB);
  endfunction

  function automatic mix_msg_t rsp_for_req(input mix_msg_t m);
    mix_msg_t r;
    case (m)
      REQ_V:     r = RSP_V;
      REQ_Odata: r = RSP_Odata;
      REQ_O:     r = RSP_O;
      REQ_WT:    r = RSP_WT;
      REQ_WB:    r = RSP_WB_ACK;
      default:   r = RSP_S;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/l2_req_responder_mem.sv
// Single-port line store for the L2 request responder: synchronous read, write-enabled write.
module l2_req_responder_mem
  import l2_req_responder_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int IDX_BITS  = $clog2(NUM_LINES),
  parameter int WIDTH     = 128
) (
  input  logic                clk,
  input  logic                we,
  input  logic [IDX_BITS-1:0] idx,
  input  logic [WIDTH-1:0]    wdata,
  output logic [WIDTH-1:0]    rdata
);

  logic [WIDTH-1:0] store [NUM_LINES];

  always_ff @(posedge clk) begin
    if (we) store[idx] <= wdata;
    rdata <= store[idx];
  end

endmodule

// File: rtl/l2_req_responder.sv
// Home-node stub answering L2 coherence requests from a direct-indexed line store, one at a time.
// Optional macro SPX_REQ_RSP_DELAY_EN adds the rsp_delay port and a programmable DELAY before RESP.
module l2_req_responder
  import l2_req_responder_pkg::*;
#(
  parameter int NUM_LINES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  mix_msg_t                      req_coh_msg,
  input  logic [`LINE_ADDR_BITS-1:0]    req_addr,
  input  logic [`BITS_PER_LINE-1:0]     req_line,
  input  logic [`WORDS_PER_LINE-1:0]    req_word_mask,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output mix_msg_t                      rsp_coh_msg,
  output logic [`LINE_ADDR_BITS-1:0]    rsp_addr,
  output logic [`BITS_PER_LINE-1:0]     rsp_line,
  output logic [`WORDS_PER_LINE-1:0]    rsp_word_mask,
  output logic [`INVACK_CNT_WIDTH-1:0]  rsp_invack_cnt,
  output logic                          err_unsup,
`ifdef SPX_REQ_RSP_DELAY_EN
  input  logic [7:0]                    rsp_delay,
`endif
  output logic [15:0]                   req_cnt
);

  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_LINES - 1);

  l2_req_responder_state_t state, state_nxt;
  logic [IDX_BITS-1:0]         init_idx;

  mix_msg_t                    req_msg_p0;
  logic [`LINE_ADDR_BITS-1:0]  req_addr_p0;
  logic [`BITS_PER_LINE-1:0]   req_line_p0;
  logic [`WORDS_PER_LINE-1:0]  req_mask_p0;
  mix_msg_t                    rsp_msg_p1;
  logic [`BITS_PER_LINE-1:0]   rsp_line_p1;

  logic                        mem_we;
  logic [IDX_BITS-1:0]         mem_idx;
  logic [`BITS_PER_LINE-1:0]   mem_wdata;
  logic [`BITS_PER_LINE-1:0]   mem_rdata;
  logic                        req_fire;
  logic                        rsp_fire;
`ifdef SPX_REQ_RSP_DELAY_EN
  logic [7:0]                  dly_cnt;
`endif

  function automatic logic [`BITS_PER_LINE-1:0] merge_words(
    input logic [`BITS_PER_LINE-1:0]  stored,
    input logic [`BITS_PER_LINE-1:0]  wr,
    input logic [`WORDS_PER_LINE-1:0] mask
  );
    logic [`BITS_PER_LINE-1:0] m;
    m = stored;
    for (int w = 0; w < `WORDS_PER_LINE; w++) begin
      if (mask[w]) m[w*`BITS_PER_WORD +: `BITS_PER_WORD] = wr[w*`BITS_PER_WORD +: `BITS_PER_WORD];
    end
    return m;
  endfunction

  assign req_fire = req_valid & req_ready;
  assign rsp_fire = rsp_valid & rsp_ready;

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = req_addr_p0[IDX_BITS-1:0];
    mem_wdata = merge_words(mem_rdata, req_line_p0, req_mask_p0);
    case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_idx   = init_idx;
        mem_wdata = '0;
        if (init_idx == LAST_IDX) state_nxt = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = READ;
      end
      READ: state_nxt = WRITE;
      WRITE: begin
        // Read data for the latched index is valid here; merge and write back in the same cycle.
        mem_we = req_is_write(req_msg_p0);
        if (!req_supported(req_msg_p0)) state_nxt = IDLE;
`ifdef SPX_REQ_RSP_DELAY_EN
        else if (rsp_delay != 8'd0) state_nxt = DELAY;
`endif
        else state_nxt = RESP;
      end
`ifdef SPX_REQ_RSP_DELAY_EN
      DELAY: if (dly_cnt == 8'd1) state_nxt = RESP;
`endif
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      init_idx  <= '0;
      err_unsup <= 1'b0;
      req_cnt   <= '0;
`ifdef SPX_REQ_RSP_DELAY_EN
      dly_cnt   <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == INIT) init_idx <= init_idx + IDX_BITS'(1);
      if ((state == WRITE) && !req_supported(req_msg_p0)) err_unsup <= 1'b1;
      if (rsp_fire && (req_cnt != 16'hFFFF)) req_cnt <= req_cnt + 16'd1;
`ifdef SPX_REQ_RSP_DELAY_EN
      if (state == WRITE) dly_cnt <= rsp_delay;
      else if (state == DELAY) dly_cnt <= dly_cnt - 8'd1;
`endif
    end
  end

  // Request capture at accept; response payload formed when the stored line arrives.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      req_msg_p0  <= req_coh_msg;
      req_addr_p0 <= req_addr;
      req_line_p0 <= req_line;
      req_mask_p0 <= req_word_mask;
    end
    if (state == WRITE) begin
      rsp_msg_p1  <= rsp_for_req(req_msg_p0);
      rsp_line_p1 <= ((req_msg_p0 == REQ_V) || (req_msg_p0 == REQ_Odata)) ? mem_rdata : '0;
    end
  end

  assign rsp_coh_msg    = rsp_valid ? rsp_msg_p1  : '0;
  assign rsp_addr       = rsp_valid ? req_addr_p0 : '0;
  assign rsp_line       = rsp_valid ? rsp_line_p1 : '0;
  assign rsp_word_mask  = rsp_valid ? req_mask_p0 : '0;
  assign rsp_invack_cnt = '0;

  l2_req_responder_mem #(
    .NUM_LINES (NUM_LINES),
    .IDX_BITS  (IDX_BITS),
    .WIDTH     (`BITS_PER_LINE)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_l2_req_responder.sv
// Directed plus randomized bench for l2_req_responder against an array-based line-store model.
module tb_l2_req_responder;
  import l2_req_responder_pkg::*;

  localparam int NL = 64;
  localparam int LW = `BITS_PER_LINE;
  localparam int WN = `WORDS_PER_LINE;
  localparam int WW = LW / WN;
  localparam int AW = `LINE_ADDR_BITS;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          req_valid;
  logic                          req_ready;
  mix_msg_t                      req_coh_msg;
  logic [AW-1:0]                 req_addr;
  logic [LW-1:0]                 req_line;
  logic [WN-1:0]                 req_word_mask;
  logic                          rsp_valid;
  logic                          rsp_ready;
  mix_msg_t                      rsp_coh_msg;
  logic [AW-1:0]                 rsp_addr;
  logic [LW-1:0]                 rsp_line;
  logic [WN-1:0]                 rsp_word_mask;
  logic [`INVACK_CNT_WIDTH-1:0]  rsp_invack_cnt;
  logic                          err_unsup;
  logic [15:0]                   req_cnt;

  always #5 clk = ~clk;

  l2_req_responder #(.NUM_LINES(NL)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_coh_msg    (req_coh_msg),
    .req_addr       (req_addr),
    .req_line       (req_line),
    .req_word_mask  (req_word_mask),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_coh_msg    (rsp_coh_msg),
    .rsp_addr       (rsp_addr),
    .rsp_line       (rsp_line),
    .rsp_word_mask  (rsp_word_mask),
    .rsp_invack_cnt (rsp_invack_cnt),
    .err_unsup      (err_unsup),
`ifdef SPX_REQ_RSP_DELAY_EN
    .rsp_delay      (8'd0),
`endif
    .req_cnt        (req_cnt)
  );

  int            vectors = 0;
  int            miscompares = 0;
  logic [LW-1:0] model [NL];
  int            exp_cnt = 0;
  bit            exp_err = 1'b0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] merge_model(input logic [LW-1:0] old, input logic [LW-1:0] nw,
                                                input logic [WN-1:0] m);
    logic [LW-1:0] r;
    for (int w = 0; w < WN; w++)
      r[w*WW +: WW] = m[w] ? nw[w*WW +: WW] : old[w*WW +: WW];
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NL; i++) model[i] = '0;
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      n++;
      tick();
    end
    chk(tag, LW'(n), LW'(NL));
  endtask

  // One full transaction; hold = cycles rsp_ready stays low once the response is up.
  task automatic do_txn(input mix_msg_t msg, input logic [AW-1:0] addr, input logic [LW-1:0] line,
                        input logic [WN-1:0] mask, input int hold);
    int            lat;
    int            idx;
    bit            sup;
    bit            seen;
    mix_msg_t      e_msg;
    logic [LW-1:0] e_line;

    req_valid = 1'b1; req_coh_msg = msg; req_addr = addr; req_line = line; req_word_mask = mask;
    rsp_ready = (hold == 0);
    lat = 0;
    while (!req_ready && lat < 100) begin tick(); lat++; end
    chk("req_ready", LW'(req_ready), LW'(1));
    tick();
    req_valid = 1'b0;

    idx = int'(addr % NL);
    sup = 1'b1;
    e_msg = RSP_S;
    e_line = '0;
    case (msg)
      REQ_V:     begin e_msg = RSP_V;      e_line = model[idx]; end
      REQ_Odata: begin e_msg = RSP_Odata;  e_line = model[idx]; end
      REQ_O:     e_msg = RSP_O;
      REQ_WT:    begin e_msg = RSP_WT;     model[idx] = merge_model(model[idx], line, mask); end
      REQ_WB:    begin e_msg = RSP_WB_ACK; model[idx] = merge_model(model[idx], line, mask); end
      default:   sup = 1'b0;
    endcase

    if (!sup) begin
      exp_err = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (rsp_valid) seen = 1'b1;
        tick();
      end
      chk("unsup_no_rsp", LW'(seen), LW'(0));
      chk("err_unsup", LW'(err_unsup), LW'(exp_err));
      rsp_ready = 1'b1;
      return;
    end

    lat = 1;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    chk("latency", LW'(lat), LW'(3));
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", LW'(rsp_valid), LW'(1));
      chk("rsp_msg", LW'(rsp_coh_msg), LW'(e_msg));
      chk("rsp_addr", LW'(rsp_addr), LW'(addr));
      chk("rsp_line", rsp_line, e_line);
      chk("rsp_mask", LW'(rsp_word_mask), LW'(mask));
      chk("rsp_invack", LW'(rsp_invack_cnt), LW'(0));
      if (i < hold) begin
        // Offer a competing request while the response is stalled.
        req_valid = 1'b1; req_coh_msg = REQ_V;
        chk("no_accept_in_resp", LW'(req_ready), LW'(0));
        tick();
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    exp_cnt++;
    chk("rsp_valid_drop", LW'(rsp_valid), LW'(0));
    chk("req_cnt", LW'(req_cnt), LW'(exp_cnt));
    chk("err_sticky", LW'(err_unsup), LW'(exp_err));
  endtask

  initial begin
    logic [LW-1:0] wt_line;
    logic [LW-1:0] exp_ac;
    logic [AW-1:0] a;
    mix_msg_t      m;
    int            r;
    int            lat;

    rst = 1'b1; req_valid = 1'b0; req_coh_msg = REQ_V; req_addr = '0; req_line = '0;
    req_word_mask = '0; rsp_ready = 1'b1;
    clear_model();
    tick();
    tick();
    chk("rst_req_ready", LW'(req_ready), LW'(0));
    chk("rst_rsp_valid", LW'(rsp_valid), LW'(0));
    chk("rst_rsp_msg", LW'(rsp_coh_msg), LW'(0));
    chk("rst_rsp_addr", LW'(rsp_addr), LW'(0));
    chk("rst_rsp_line", rsp_line, '0);
    chk("rst_rsp_mask", LW'(rsp_word_mask), LW'(0));
    chk("rst_invack", LW'(rsp_invack_cnt), LW'(0));
    chk("rst_err", LW'(err_unsup), LW'(0));
    chk("rst_cnt", LW'(req_cnt), LW'(0));

    // INIT length with req_valid held high throughout
    rst = 1'b0;
    req_valid = 1'b1; req_coh_msg = REQ_V; req_addr = AW'(32'h10); req_word_mask = '1;
    wait_init("init_cycles");
    do_txn(REQ_V, AW'(32'h10), '0, '1, 0);

    // Masked write-through then read-back
    wt_line = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    exp_ac  = {32'h0, 32'hCCCC_0003, 32'h0, 32'hAAAA_0001};
    do_txn(REQ_WT, AW'(32'h5), wt_line, 4'b0101, 0);
    do_txn(REQ_V, AW'(32'h5), '0, '1, 0);
    chk("wt_readback_model", model[5], exp_ac);

    // Stalled response
    do_txn(REQ_Odata, AW'(32'h5), '0, 4'b1111, 10);

    // Unsupported request, then a normal read
    do_txn(REQ_S, AW'(32'h7), '0, '1, 0);
    do_txn(5'd20, AW'(32'h9), '0, '1, 0);
    do_txn(REQ_V, AW'(32'h45), '0, 4'b0011, 0);

    // Zero-mask write and aliasing through the upper address bits
    do_txn(REQ_WB, AW'(32'h105), {4{32'hFFFF_FFFF}}, 4'b0000, 1);
    do_txn(REQ_O, AW'(32'h305), {4{32'h1234_5678}}, 4'b1111, 0);

    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3)      m = REQ_V;
      else if (r < 5) m = REQ_WT;
      else if (r < 6) m = REQ_WB;
      else if (r < 7) m = REQ_Odata;
      else if (r < 8) m = REQ_O;
      else if (r < 9) m = REQ_V;
      else            m = 5'd20;
      a = AW'($urandom);
      a[5:0] = 6'($urandom_range(0, 7));
      do_txn(m, a, {$urandom, $urandom, $urandom, $urandom}, WN'($urandom),
             int'($urandom_range(0, 3)));
    end

    // Reset while a response is pending
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_coh_msg = REQ_V; req_addr = AW'(32'h5); req_word_mask = '1;
    lat = 0;
    while (!req_ready && lat < 100) begin tick(); lat++; end
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    chk("pre_rst_rsp_valid", LW'(rsp_valid), LW'(1));
    rst = 1'b1;
    tick();
    chk("rst_in_resp_valid", LW'(rsp_valid), LW'(0));
    chk("rst_in_resp_cnt", LW'(req_cnt), LW'(0));
    chk("rst_in_resp_err", LW'(err_unsup), LW'(0));
    rst = 1'b0;
    rsp_ready = 1'b1;
    clear_model();
    exp_cnt = 0;
    exp_err = 1'b0;
    wait_init("reinit_cycles");
    do_txn(REQ_V, AW'(32'h5), '0, '1, 0);
    do_txn(REQ_Odata, AW'(32'h3), '0, '1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
